// File: rtl/dmem_stack_pkg.sv
// Shared types for the MEM-stage data memory / hardware stack unit:
// operation codes, sticky fault causes and the two-state fault FSM.
package dmem_stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_PUSH = 3'd3,
        OP_POP  = 3'd4,
        OP_CALL = 3'd5,
        OP_RET  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_OVERFLOW   = 3'd1,
        ERR_UNDERFLOW  = 3'd2,
        ERR_MISALIGNED = 3'd3,
        ERR_RANGE      = 3'd4
    } err_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte-lane write enables and an
// asynchronous aligned word read, so a write is visible to the next cycle's read.
module dmem_byte_array #(
    parameter int WB    = 4,
    parameter int IDX_W = 8
) (
    input  logic                clk,
    input  logic [WB-1:0]       i_we,
    input  logic [IDX_W-1:0]    i_widx,
    input  logic [8*WB-1:0]     i_wdata,
    input  logic [IDX_W-1:0]    i_ridx,
    output logic [8*WB-1:0]     o_rdata
);

    logic [8*WB-1:0] r_mem [2**IDX_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WB; b++) begin
            if (i_we[b]) begin
                r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/dmem_stack_unit.sv
// Little-endian data memory plus full-descending stack with sticky fault FSM.
// Define DMEM_BYTE_STROBE_EN to add a wstrb port that masks SW byte lanes.
module dmem_stack_unit
    import dmem_stack_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32,
    parameter int STACK_LIMIT = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   pc,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0] wstrb,
`endif
    input  logic                fault_clr,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   sp_out,
    output logic                err,
    output logic [2:0]          err_code
);

    localparam int WB    = DATA_W / 8;
    localparam int LG_WB = $clog2(WB);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IDX_W = AW - LG_WB;

    // Bounds are compared one bit wider than the address so addr+WB cannot wrap.
    localparam logic [ADDR_W:0]   C_WB    = (ADDR_W+1)'(WB);
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [ADDR_W:0]   C_LIMIT = (ADDR_W+1)'(STACK_LIMIT);
    localparam logic [ADDR_W-1:0] K_WB    = ADDR_W'(WB);
    localparam logic [ADDR_W-1:0] K_EMPTY = ADDR_W'(DEPTH_BYTES);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_sp;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    err_e                r_err_code;

    op_e                 w_op;
    logic [ADDR_W:0]     w_addr_end;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_overflow;
    logic                w_underflow;
    logic [ADDR_W-1:0]   w_sp_dec;
    logic [ADDR_W-1:0]   w_sp_inc;
    logic                w_accept;
    logic                w_fault;
    logic                w_do_write;
    err_e                w_err_code;
    logic [WB-1:0]       w_lane_mask;
    logic [WB-1:0]       w_we;
    logic [IDX_W-1:0]    w_widx;
    logic [IDX_W-1:0]    w_ridx;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_op           = op_e'(op);
    assign w_addr_end     = {1'b0, addr} + C_WB;
    assign w_misaligned   = |addr[LG_WB-1:0];
    assign w_out_of_range = w_addr_end > C_DEPTH;
    assign w_overflow     = {1'b0, r_sp} < (C_LIMIT + C_WB);
    assign w_underflow    = ({1'b0, r_sp} + C_WB) > C_DEPTH;
    assign w_sp_dec       = r_sp - K_WB;
    assign w_sp_inc       = r_sp + K_WB;
    assign w_accept       = req_valid && (r_state == ST_RUN);

    // Misalignment is reported ahead of out-of-range for LW/SW.
    always_comb begin
        w_err_code  = ERR_NONE;
        w_do_write  = 1'b0;
        w_lane_mask = '1;
        w_widx      = addr[AW-1:LG_WB];
        w_ridx      = addr[AW-1:LG_WB];
        w_wr_data   = wdata;
        case (w_op)
            OP_LW, OP_SW: begin
                if (w_misaligned) begin
                    w_err_code = ERR_MISALIGNED;
                end else if (w_out_of_range) begin
                    w_err_code = ERR_RANGE;
                end
                w_do_write = (w_op == OP_SW);
`ifdef DMEM_BYTE_STROBE_EN
                w_lane_mask = wstrb;
`endif
            end
            OP_PUSH, OP_CALL: begin
                if (w_overflow) begin
                    w_err_code = ERR_OVERFLOW;
                end
                w_do_write = 1'b1;
                w_widx     = w_sp_dec[AW-1:LG_WB];
                w_wr_data  = (w_op == OP_CALL) ? DATA_W'(pc) : wdata;
            end
            OP_POP, OP_RET: begin
                if (w_underflow) begin
                    w_err_code = ERR_UNDERFLOW;
                end
                w_ridx = r_sp[AW-1:LG_WB];
            end
            default: ;
        endcase
    end

    assign w_fault = (w_err_code != ERR_NONE);
    assign w_we    = (w_accept && !w_fault && w_do_write) ? w_lane_mask : '0;

    dmem_byte_array #(
        .WB    (WB),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (w_widx),
        .i_wdata (w_wr_data),
        .i_ridx  (w_ridx),
        .o_rdata (w_rd_word)
    );

    // FAULT swallows every request until fault_clr; the cause stays visible meanwhile.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_sp        <= K_EMPTY;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            r_state    <= ST_FAULT;
                            r_err      <= 1'b1;
                            r_err_code <= w_err_code;
                        end else begin
                            case (w_op)
                                OP_LW: begin
                                    r_rdata     <= w_rd_word;
                                    r_rsp_valid <= 1'b1;
                                end
                                OP_POP, OP_RET: begin
                                    r_rdata     <= w_rd_word;
                                    r_rsp_valid <= 1'b1;
                                    r_sp        <= w_sp_inc;
                                end
                                OP_PUSH, OP_CALL: begin
                                    r_sp <= w_sp_dec;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        r_state    <= ST_RUN;
                        r_err_code <= ERR_NONE;
                    end
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_RUN);
    assign rsp_valid = r_rsp_valid;
    assign rdata     = r_rdata;
    assign sp_out    = r_sp;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
